// File: rtl/dmem_io.sv
// Memory-mapped data port for a small core: 64-word RAM, LED register,
// free-running cycle counter and a 4-deep byte FIFO feeding a TX sink.
module dmem_io (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  // Word addresses (byte address >> 2) of the I/O registers.
  localparam logic [29:0] W_LED    = 30'h3FFF_C000;
  localparam logic [29:0] W_CYCLE  = 30'h3FFF_C001;
  localparam logic [29:0] W_TXDATA = 30'h3FFF_C002;
  localparam logic [29:0] W_TXSTAT = 30'h3FFF_C003;

  logic [31:0] ram [64];
  logic [7:0]  fifo [4];
  logic [31:0] cycle;
  logic [1:0]  wptr, rptr;
  logic [2:0]  count;

  logic [29:0] word;
  logic        sel_ram, sel_led, sel_cycle, sel_txdata, sel_txstat;
  logic        push, pop;
  logic        addr_lsb_unused;

  assign word            = aluout[31:2];
  assign addr_lsb_unused = ^aluout[1:0];
  assign sel_ram         = (aluout[31:8] == 24'h0);
  assign sel_led         = (word == W_LED);
  assign sel_cycle       = (word == W_CYCLE);
  assign sel_txdata      = (word == W_TXDATA);
  assign sel_txstat      = (word == W_TXSTAT);

  // TX handshake: a byte transfers on a rising clk where tx_valid && tx_ready;
  // tx_data holds the FIFO head and cannot change while tx_valid && !tx_ready.
  assign tx_valid = (count != 3'd0);
  assign tx_data  = fifo[rptr];
  assign pop      = tx_valid && tx_ready;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push     = memwrite && sel_txdata && ((count != 3'd4) || pop);

  // Storage arrays carry no reset; only the pointers/count define content.
  always_ff @(posedge clk) begin
    if (memwrite && sel_ram) ram[aluout[7:2]] <= writedata;
    if (push) fifo[wptr] <= writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led   <= 8'h00;
      cycle <= 32'h0;
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
    end else begin
      if (memwrite && sel_led) led <= writedata[7:0];
      if (memwrite && sel_cycle) cycle <= writedata;
      else                       cycle <= cycle + 32'd1;
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    readdata = 32'h0;
    if (sel_ram)         readdata = ram[aluout[7:2]];
    else if (sel_led)    readdata = {24'h0, led};
    else if (sel_cycle)  readdata = cycle;
    else if (sel_txstat) readdata = {27'h0, count, (count == 3'd0), (count == 3'd4)};
  end

endmodule

// File: tb/tb_dmem_io.sv
// Directed bench for dmem_io: a queue/array model checked every negedge plus
// literal expectations for the RAM, LED, CYCLE, TX FIFO and reset scenarios.
module tb_dmem_io;

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
  localparam logic [31:0] A_TXSTAT = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int errors = 0;
  int checks = 0;

  dmem_io dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .led       (led),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model state
  logic [31:0] m_mem [64];
  bit          m_known [64];
  logic [7:0]  m_led = 8'h00;
  logic [31:0] m_cycle = 32'h0;
  logic [7:0]  exp_q [$];
  bit          m_pop, m_push;
  logic [31:0] m_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    int n;
    known = 1'b1;
    n = exp_q.size();
    if (a[31:8] == 24'h0) begin
      known = m_known[a[7:2]];
      return m_mem[a[7:2]];
    end
    case ({a[31:2], 2'b00})
      A_LED:    return {24'h0, m_led};
      A_CYCLE:  return m_cycle;
      A_TXSTAT: return 32'(n * 4 + ((n == 0) ? 2 : 0) + ((n == 4) ? 1 : 0));
      default:  return 32'h0;
    endcase
  endfunction

  always @(negedge reset) begin
    exp_q.delete();
    m_led   = 8'h00;
    m_cycle = 32'h0;
  end

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_word = {aluout[31:2], 2'b00};
      m_pop  = (exp_q.size() > 0) && (tx_ready === 1'b1);
      m_push = memwrite && (m_word == A_TXDATA) && ((exp_q.size() < 4) || m_pop);
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(writedata[7:0]);
      if (memwrite && m_word == A_CYCLE) m_cycle = writedata;
      else                               m_cycle = m_cycle + 32'd1;
      if (memwrite && m_word == A_LED) m_led = writedata[7:0];
      if (memwrite && aluout[31:8] == 24'h0) begin
        m_mem[aluout[7:2]]   = writedata;
        m_known[aluout[7:2]] = 1'b1;
      end
    end
  end

  // compare process
  logic [31:0] cmp_exp;
  bit          cmp_known;
  always @(negedge clk) begin
    chk("led", {24'h0, led}, {24'h0, m_led});
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, exp_q.size() != 0});
    if (exp_q.size() > 0) chk("tx_data", {24'h0, tx_data}, {24'h0, exp_q[0]});
    cmp_exp = m_read(aluout, cmp_known);
    if (cmp_known) chk("readdata", readdata, cmp_exp);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    step();
    memwrite  = 1'b1;
    aluout    = addr;
    writedata = data;
    step();
    memwrite  = 1'b0;
  endtask

  logic [7:0] drain [4];

  initial begin
    reset = 1'b0; memwrite = 1'b0; aluout = 32'h0; writedata = 32'h0; tx_ready = 1'b0;
    step(); step();
    aluout = A_CYCLE; #1;
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_txvalid", {31'h0, tx_valid}, 32'h0);
    chk("rst_cycle", readdata, 32'h0);
    step(); reset = 1'b1; #1;
    chk("cycle_first", readdata, 32'h0);
    step(); #1;
    chk("cycle_inc", readdata, 32'h1);

    // RAM
    store(32'h10, 32'hDEADBEEF);
    store(32'h00, 32'h01234567);
    store(32'hFC, 32'h89ABCDEF);
    aluout = 32'h10; #1; chk("ram_10", readdata, 32'hDEADBEEF);
    aluout = 32'h13; #1; chk("ram_13", readdata, 32'hDEADBEEF);
    aluout = 32'h100; #1; chk("ram_100", readdata, 32'h0);
    aluout = 32'hFC; #1; chk("ram_fc", readdata, 32'h89ABCDEF);

    // LED / CYCLE
    store(A_LED, 32'h000001A5);
    aluout = A_LED; #1;
    chk("led_a5", {24'h0, led}, 32'hA5);
    chk("led_read", readdata, 32'hA5);
    store(A_CYCLE, 32'hFFFFFFFE);
    aluout = A_CYCLE; #1; chk("cycle_load", readdata, 32'hFFFFFFFE);
    step(); #1; chk("cycle_ff", readdata, 32'hFFFFFFFF);
    step(); #1; chk("cycle_wrap", readdata, 32'h0);

    // unmapped stores have no effect
    store(32'hFFFF0010, 32'h123);
    store(32'h200, 32'h456);
    aluout = 32'hFFFF0010; #1; chk("unmapped_rd", readdata, 32'h0);
    aluout = 32'h200; #1; chk("unmapped_rd2", readdata, 32'h0);
    aluout = 32'h0; #1; chk("ram_no_alias", readdata, 32'h01234567);
    chk("led_kept", {24'h0, led}, 32'hA5);

    // FIFO fill, drop, drain
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(A_TXDATA, 32'(8'h11 * (i + 1)));
    aluout = A_TXSTAT; #1; chk("txstat_full", readdata, 32'h11);
    aluout = A_TXDATA; #1; chk("txdata_read", readdata, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("drain1", {24'h0, tx_data}, 32'(8'h11 * (i + 1)));
      step();
    end
    chk("drain1_empty", {31'h0, tx_valid}, 32'h0);
    aluout = A_TXSTAT; #1; chk("txstat_empty", readdata, 32'h02);

    // full with simultaneous push and pop
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(A_TXDATA, 32'(8'h11 * (i + 1)));
    memwrite = 1'b1; aluout = A_TXDATA; writedata = 32'h66; tx_ready = 1'b1;
    step();
    memwrite = 1'b0; aluout = A_TXSTAT; #1;
    chk("txstat_pushpop", readdata, 32'h11);
    drain = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin
      #1; chk("drain2", {24'h0, tx_data}, {24'h0, drain[i]});
      step();
    end
    chk("drain2_empty", {31'h0, tx_valid}, 32'h0);

    // asynchronous reset mid-operation
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(A_TXDATA, 32'(8'hA1 + i));
    store(A_LED, 32'hFF);
    aluout = A_CYCLE; #1;
    chk("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
    chk("pre_rst_led", {24'h0, led}, 32'hFF);
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", {31'h0, tx_valid}, 32'h0);
    chk("arst_led", {24'h0, led}, 32'h0);
    chk("arst_cycle", readdata, 32'h0);
    #2 reset = 1'b1; aluout = A_TXSTAT;
    #1; chk("arst_txstat", readdata, 32'h02);
    aluout = A_CYCLE; #1; chk("arst_cycle0", readdata, 32'h0);
    step(); #1; chk("arst_cycle1", readdata, 32'h1);

    // FIFO usable after reset
    store(A_TXDATA, 32'h77);
    aluout = A_TXSTAT; #1;
    chk("post_txstat", readdata, 32'h04);
    chk("post_txdata", {24'h0, tx_data}, 32'h77);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_io.md
DMEM_IO -- requirements
Module: dmem_io

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: memwrite  in  1  store strobe from core, sampled on rising clk.
REQ-004 SHALL have ports: aluout  in  32  byte address from core; addr[1:0] ignored (word access only).
REQ-005 SHALL have ports: writedata  in  32  store data from core.
REQ-006 SHALL have ports: readdata  out  32  load data to core, combinational from aluout and current state.
REQ-007 SHALL have ports: led  out  8  LED register contents.
REQ-008 SHALL have ports: tx_data  out  8  byte at TX FIFO head.
REQ-009 SHALL have ports: tx_valid  out  1  high when TX FIFO not empty.
REQ-010 SHALL have ports: tx_ready  in  1  downstream sink accepts byte when tx_valid && tx_ready at rising clk.

Function
REQ-011 SHALL decode address map: RAM 0x00000000-0x000000FC (aluout[31:8]==0, index aluout[7:2], 64x32); LED 0xFFFF0000; CYCLE 0xFFFF0004; TXDATA 0xFFFF0008; TXSTAT 0xFFFF000C.
REQ-012 SHALL return readdata = 0 for any unmapped address; stores to unmapped addresses have no effect.
REQ-013 SHALL perform RAM reads combinationally (zero latency, same cycle as address); RAM writes take effect at the rising edge with memwrite=1, visible to reads the following cycle.
REQ-014 SHALL not reset RAM contents; RAM is not initialised by reset.
REQ-015 LED: store writes writedata[7:0] into led at rising edge; read returns {24'b0, led}.
REQ-016 CYCLE: 32-bit counter increments by 1 every clk; wraps 0xFFFFFFFF -> 0x00000000; read returns current registered value.
REQ-017 CYCLE store loads writedata into counter at that edge; store takes priority over increment (next-cycle read = writedata+1 one cycle later).
REQ-018 TX FIFO: 4 entries of 8 bits, circular read/write pointers, 3-bit count 0..4.
REQ-019 Store to TXDATA pushes writedata[7:0] at rising edge if count<4, or if count==4 and a pop occurs the same edge; otherwise the byte is silently dropped.
REQ-020 Pop occurs at rising edge when tx_valid && tx_ready; head advances, count decrements.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-022 tx_valid = (count != 0); tx_data = head entry; tx_data value is don't-care when tx_valid=0 but SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-023 Read of TXDATA returns 0; read of TXSTAT returns {27'b0, count[2:0], empty, full} (bit0 full = count==4, bit1 empty = count==0, bits4:2 count).
REQ-024 Pointers wrap modulo 4 without affecting count.
REQ-025 Reads SHALL have no side effects on any state.

Reset
REQ-026 On reset=0 (asynchronous, immediately): led=0, cycle counter=0, FIFO pointers and count=0, tx_valid=0.
REQ-027 Reset mid-operation SHALL discard all queued TX bytes; a store coincident with reset assertion is lost.
REQ-028 After reset deasserts, counter reads 0 in the first cycle and increments from the first rising edge with reset=1.

Verification
REQ-029 RAM: store 0xDEADBEEF to 0x00000010, then load 0x00000010 and 0x00000013 -> both return 0xDEADBEEF; load 0x00000100 -> 0.
REQ-030 LED/CYCLE: after reset, store 0x000001A5 to LED -> led=0xA5, load LED = 0x000000A5; store 0xFFFFFFFE to CYCLE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on successive cycles.
REQ-031 FIFO full/drop: tx_ready=0, store bytes 0x11,0x22,0x33,0x44,0x55 -> TXSTAT = 0x11 (count 4, full), 0x55 dropped; then tx_ready=1 -> tx_data 0x11,0x22,0x33,0x44 on successive edges, then tx_valid=0, TXSTAT=0x02.
REQ-032 Full with simultaneous push/pop: FIFO full (0x11..0x44), tx_ready=1, store 0x66 same cycle -> count stays 4, drained order 0x22,0x33,0x44,0x66.
REQ-033 Async reset: with 3 bytes queued and led=0xFF, pulse reset=0 between clock edges -> tx_valid, led and counter go to 0 before next edge; TXSTAT=0x02 after release.
